instr_fetch: RTL and testbench

Instruction fetch stage for the single-issue RISC-V core. Holds the program counter, issues one word read per instruction on the core's memory read port (address/valid, ack/data), and hands each fetched instruction with its PC to the instruction handler over a valid/ready handshake. Sits between instruction memory and the instruction handler; accepts PC redirects (branches/jumps) from the handler.

---
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read per instruction and hands
// instructions to the handler. Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects in ERR.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_rd_addr,
    output logic        mem_rd_addr_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_ack,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        squash_q, squash_d;
    logic        addr_valid_q, addr_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] redir_pc;
    logic        redir_bad;

    // Low address bits are dropped so the fetch address is always word aligned.
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        squash_d      = squash_q;
        addr_valid_d  = addr_valid_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                addr_d       = pc_d;
                addr_valid_d = 1'b1;
                state_d      = REQ;
            end
            REQ: begin
                if (mem_rd_ack) begin
                    if (squash_q || redirect_valid) begin
                        // Stale data for a redirected stream: drop it and refetch.
                        squash_d = 1'b0;
                        if (redirect_valid) begin
                            pc_d = redir_pc;
                        end
                        addr_d = pc_d;
                    end else begin
                        instr_d       = mem_rd_data;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + 32'd4;
                        addr_valid_d  = 1'b0;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d     = redir_pc;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redir_pc;
                    addr_d        = redir_pc;
                    addr_valid_d  = 1'b1;
                    state_d       = REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    addr_d        = pc_q;
                    addr_valid_d  = 1'b1;
                    state_d       = REQ;
                end
            end
            default: begin
            end
        endcase
        // Misaligned redirect overrides everything and parks the stage until reset.
        if (redir_bad) begin
            state_d       = ERR;
            pc_d          = pc_q;
            squash_d      = 1'b0;
            addr_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
            fetch_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            squash_q      <= 1'b0;
            addr_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            squash_q      <= squash_d;
            addr_valid_q  <= addr_valid_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign mem_rd_addr       = addr_q;
    assign mem_rd_addr_valid = addr_valid_q;
    assign instr             = instr_q;
    assign instr_pc          = instr_pc_q;
    assign instr_valid       = instr_valid_q;
    assign fetch_err         = fetch_err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a word memory with random latency and a handler
// with random stalls, checked against an expected linear PC stream and redirect targets.
module tb_instr_fetch;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] m_addr, m_data, i_instr, i_pc, r_pc;
    logic        m_valid, m_ack, i_valid, i_ready, r_valid, f_err;

    logic [31:0] m2_addr, m2_data, i2_instr, i2_pc;
    logic        m2_valid, i2_valid, f2_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] next_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_0133;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .mem_rd_addr(m_addr), .mem_rd_addr_valid(m_valid),
        .mem_rd_data(m_data), .mem_rd_ack(m_ack),
        .instr(i_instr), .instr_pc(i_pc), .instr_valid(i_valid), .instr_ready(i_ready),
        .redirect_valid(r_valid), .redirect_pc(r_pc), .fetch_err(f_err)
    );

    // Second instance: zero-wait memory, always-ready handler, PC starting at the top of memory.
    assign m2_data = mem_word(m2_addr);
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .mem_rd_addr(m2_addr), .mem_rd_addr_valid(m2_valid),
        .mem_rd_data(m2_data), .mem_rd_ack(m2_valid),
        .instr(i2_instr), .instr_pc(i2_pc), .instr_valid(i2_valid), .instr_ready(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .fetch_err(f2_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch n sequential instructions from next_pc; memory latency and handler stalls random.
    task automatic run_stream(input int n, input int dmin, input int dmax,
                              input int smin, input int smax);
        logic [31:0] exp;
        int d, s;
        for (int i = 0; i < n; i++) begin
            exp = next_pc;
            checks++;
            if (m_valid !== 1'b1 || m_addr !== exp) begin
                failures++;
                $display("FAIL req_addr: valid=%b addr=%h, required valid=1 addr=%h", m_valid, m_addr, exp);
            end
            d = int'($urandom_range(dmax, dmin));
            for (int k = 0; k < d; k++) begin
                m_ack = 1'b0;
                m_data = $urandom;
                tick();
                checks++;
                if (m_valid !== 1'b1 || m_addr !== exp || i_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL req_wait: valid=%b addr=%h ivalid=%b, required 1/%h/0", m_valid, m_addr, i_valid, exp);
                end
            end
            m_ack = 1'b1;
            m_data = mem_word(m_addr);
            tick();
            m_ack = 1'b0;
            m_data = $urandom;
            checks++;
            if (i_valid !== 1'b1 || i_instr !== mem_word(exp) || i_pc !== exp || m_valid !== 1'b0) begin
                failures++;
                $display("FAIL deliver: ivalid=%b instr=%h pc=%h mvalid=%b, required 1/%h/%h/0",
                         i_valid, i_instr, i_pc, m_valid, mem_word(exp), exp);
            end
            $display("fetch pc=%h instr=%h ack_delay=%0d", i_pc, i_instr, d);
            s = int'($urandom_range(smax, smin));
            for (int k = 0; k < s; k++) begin
                i_ready = 1'b0;
                tick();
                checks++;
                if (i_valid !== 1'b1 || i_instr !== mem_word(exp) || i_pc !== exp || m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_stable: ivalid=%b instr=%h pc=%h mvalid=%b, required 1/%h/%h/0",
                             i_valid, i_instr, i_pc, m_valid, mem_word(exp), exp);
                end
            end
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            checks++;
            if (i_valid !== 1'b0) begin
                failures++;
                $display("FAIL transfer: ivalid=%b, required 0", i_valid);
            end
            next_pc = exp + 32'd4;
        end
    endtask

    // From REQ with a zero-wait ack, land in HOLD holding the instruction at next_pc.
    task automatic go_hold();
        m_ack = 1'b1;
        m_data = mem_word(m_addr);
        tick();
        m_ack = 1'b0;
        checks++;
        if (i_valid !== 1'b1 || i_pc !== next_pc) begin
            failures++;
            $display("FAIL go_hold: ivalid=%b pc=%h, required 1/%h", i_valid, i_pc, next_pc);
        end
        next_pc = next_pc + 32'd4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_addr !== 32'h0 || m_valid !== 1'b0 || i_valid !== 1'b0 || i_instr !== 32'h0 ||
            i_pc !== 32'h0 || f_err !== 1'b0 || m2_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL reset_state: addr=%h mv=%b iv=%b instr=%h pc=%h err=%b addr2=%h",
                     m_addr, m_valid, i_valid, i_instr, i_pc, f_err, m2_addr);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: valid=%b addr=%h, required 1/00000000", m_valid, m_addr);
        end
        next_pc = 32'h0;
        $display("reset released, first request addr=%h", m_addr);
    endtask

    task automatic test_sequential();
        run_stream(2, 0, 0, 0, 0);
    endtask

    task automatic test_redirect_req();
        r_valid = 1'b1;
        r_pc = 32'h100;
        tick();
        r_valid = 1'b0;
        checks++;
        if (m_addr !== 32'h8 || m_valid !== 1'b1 || i_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_req_hold: addr=%h mv=%b iv=%b, required 00000008/1/0", m_addr, m_valid, i_valid);
        end
        repeat (2) tick();
        m_ack = 1'b1;
        m_data = mem_word(32'h8);
        tick();
        m_ack = 1'b0;
        checks++;
        if (i_valid !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_req_drop: iv=%b mv=%b addr=%h, required 0/1/00000100", i_valid, m_valid, m_addr);
        end
        $display("redirect in REQ to 100, request addr=%h", m_addr);
        r_valid = 1'b1;
        r_pc = 32'h200;
        m_ack = 1'b1;
        m_data = mem_word(m_addr);
        tick();
        r_valid = 1'b0;
        m_ack = 1'b0;
        checks++;
        if (i_valid !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h200) begin
            failures++;
            $display("FAIL redir_with_ack: iv=%b mv=%b addr=%h, required 0/1/00000200", i_valid, m_valid, m_addr);
        end
        next_pc = 32'h200;
        run_stream(2, 1, 3, 0, 2);
    endtask

    task automatic test_stall();
        run_stream(2, 3, 3, 4, 4);
    endtask

    task automatic test_redirect_hold();
        go_hold();
        r_valid = 1'b1;
        r_pc = 32'h40;
        i_ready = 1'b1;
        tick();
        r_valid = 1'b0;
        i_ready = 1'b0;
        checks++;
        if (i_valid !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h40) begin
            failures++;
            $display("FAIL redir_hold: iv=%b mv=%b addr=%h, required 0/1/00000040", i_valid, m_valid, m_addr);
        end
        next_pc = 32'h40;
        run_stream(1, 0, 2, 0, 2);
    endtask

    task automatic test_random();
        run_stream(25, 0, 4, 0, 4);
    endtask

    task automatic test_misaligned();
        go_hold();
        r_valid = 1'b1;
        r_pc = 32'h102;
        tick();
        r_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (f_err !== 1'b1 || m_valid !== 1'b0 || i_valid !== 1'b0) begin
                failures++;
                $display("FAIL err_sticky: err=%b mv=%b iv=%b, required 1/0/0", f_err, m_valid, i_valid);
            end
            m_ack = 1'($urandom);
            i_ready = 1'($urandom);
            tick();
        end
        m_ack = 1'b0;
        i_ready = 1'b0;
        $display("misaligned redirect trapped, fetch_err=%b", f_err);
`else
        checks++;
        if (f_err !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h100) begin
            failures++;
            $display("FAIL misalign_mask: err=%b mv=%b addr=%h, required 0/1/00000100", f_err, m_valid, m_addr);
        end
        next_pc = 32'h100;
        run_stream(1, 0, 1, 0, 1);
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || i_valid !== 1'b0 || f_err !== 1'b0 || m_addr !== 32'h0 || i_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: mv=%b iv=%b err=%b addr=%h pc=%h", m_valid, i_valid, f_err, m_addr, i_pc);
        end
        reset = 1'b0;
        m_ack = 1'b1;
        m_data = 32'hDEAD_BEEF;
        tick();
        m_ack = 1'b0;
        checks++;
        if (i_valid !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h0) begin
            failures++;
            $display("FAIL late_ack: iv=%b mv=%b addr=%h, required 0/1/00000000", i_valid, m_valid, m_addr);
        end
        next_pc = 32'h0;
        go_hold();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (i_valid !== 1'b0 || i_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: iv=%b instr=%h, required 0/00000000", i_valid, i_instr);
        end
        tick();
        next_pc = 32'h0;
        run_stream(2, 0, 2, 0, 2);
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] seen[$];
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 20 && seen.size() < 3; k++) begin
            tick();
            if (m2_valid === 1'b1) seen.push_back(m2_addr);
        end
        checks++;
        if (seen.size() != 3) begin
            failures++;
            $display("FAIL wrap_timeout: got %0d requests, required 3", seen.size());
        end else begin
            checks++;
            if (seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0 || seen[2] !== 32'h4) begin
                failures++;
                $display("FAIL wrap_addr: got %h %h %h, required fffffffc 00000000 00000004",
                         seen[0], seen[1], seen[2]);
            end
            $display("wrap requests %h %h %h", seen[0], seen[1], seen[2]);
        end
    endtask

    initial begin
        reset = 1'b1;
        m_ack = 1'b0;
        m_data = 32'h0;
        i_ready = 1'b0;
        r_valid = 1'b0;
        r_pc = 32'h0;
        next_pc = 32'h0;
        test_reset();
        test_sequential();
        test_redirect_req();
        test_stall();
        test_redirect_hold();
        test_random();
        test_misaligned();
        test_reset_mid();
        test_reset_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
